// File: rtl/bitonic_sorter_stream.sv
// Streaming candidate sorter.
// Collects up to CAND_NUM pT words into a frame, ranks them with a bitonic
// network and streams the top OUT_NUM candidates (pT plus arrival slot) out
// over a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_FILL | accepting words into slots; in_ready high
// S_SORT | network settling; inputs ignored; busy high
// S_DRAIN| presenting rank rd_ptr; advances on out_valid && out_ready
//
// The bitonic network is combinational from the slot registers.  The slots
// are frozen for the whole of S_SORT, so the network is given SORT_LAT
// multicycle settle time.  One further S_SORT cycle then captures the top
// ranks into r_rank_*, which means the first out_valid appears
// SORT_LAT+1 edges after the closing word is accepted.
module bitonic_sorter_stream #(
  parameter  int CAND_NUM  = 16,
  parameter  int PT_WIDTH  = 4,
  parameter  int OUT_NUM   = 4,
  parameter  int SORT_LAT  = 4,
  localparam int IDX_WIDTH = $clog2(CAND_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PT_WIDTH-1:0]  in_pt,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PT_WIDTH-1:0]  out_pt,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int RD_WIDTH  = $clog2(OUT_NUM + 1);
  localparam int CNT_WIDTH = $clog2(SORT_LAT + 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // Only pT is stored per slot: a slot's arrival index is its position.
  logic [PT_WIDTH-1:0]    r_slot_pt [CAND_NUM];
  logic [IDX_WIDTH-1:0]   r_wr_ptr;
  logic [RD_WIDTH-1:0]    r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_sort_cnt;
  logic [PT_WIDTH-1:0]    r_rank_pt  [OUT_NUM];
  logic [IDX_WIDTH-1:0]   r_rank_idx [OUT_NUM];

  logic [PT_WIDTH-1:0]    w_net_pt  [CAND_NUM];
  logic [IDX_WIDTH-1:0]   w_net_idx [CAND_NUM];

  logic                   w_accept;
  logic                   w_close;
  logic                   w_sort_done;
  logic                   w_last_rank;
  logic                   w_out_fire;
  logic                   w_frame_done;

  assign w_accept     = (r_state == S_FILL) && in_valid;
  assign w_close      = w_accept && (in_last || (r_wr_ptr == IDX_WIDTH'(CAND_NUM - 1)));
  assign w_sort_done  = (r_state == S_SORT) && (r_sort_cnt == '0);
  assign w_last_rank  = (r_rd_ptr == RD_WIDTH'(OUT_NUM - 1));
  assign w_out_fire   = (r_state == S_DRAIN) && out_ready;
  assign w_frame_done = w_out_fire && w_last_rank;

  assign in_ready  = (r_state == S_FILL);
  assign busy      = (r_state == S_SORT) || (r_state == S_DRAIN);
  assign out_valid = (r_state == S_DRAIN);
  assign out_last  = (r_state == S_DRAIN) && w_last_rank;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_close)      w_state_nxt = S_SORT;
      S_SORT:  if (w_sort_done)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_frame_done) w_state_nxt = S_FILL;
      default:                   w_state_nxt = S_FILL;
    endcase
  end

  // Slot storage: written on accept, wiped to pt=0 when the frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CAND_NUM; i++) r_slot_pt[i] <= '0;
    end else if (w_accept) begin
      r_slot_pt[r_wr_ptr] <= in_pt;
    end else if (w_frame_done) begin
      for (int i = 0; i < CAND_NUM; i++) r_slot_pt[i] <= '0;
    end
  end

  // Write pointer: saturates at the last slot, returns to 0 after the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_frame_done) begin
      r_wr_ptr <= '0;
    end else if (w_accept && (r_wr_ptr != IDX_WIDTH'(CAND_NUM - 1))) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Sort settle timer: down-counter loaded when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sort_cnt <= '0;
    end else if (w_close) begin
      r_sort_cnt <= CNT_WIDTH'(SORT_LAT);
    end else if ((r_state == S_SORT) && (r_sort_cnt != '0)) begin
      r_sort_cnt <= r_sort_cnt - 1'b1;
    end
  end

  // Read pointer: steps through ranks on each output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_out_fire) begin
      if (w_last_rank) r_rd_ptr <= '0;
      else             r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Bitonic network, descending on key {pt, ~idx}: higher pT first, lower
  // arrival index wins ties.  Indices are unique so the order is total.
  always_comb begin
    logic [PT_WIDTH-1:0]  w_tmp_pt;
    logic [IDX_WIDTH-1:0] w_tmp_idx;
    logic                 w_i_higher;
    int                   w_l;
    w_tmp_pt   = '0;
    w_tmp_idx  = '0;
    w_i_higher = 1'b0;
    w_l        = 0;
    for (int i = 0; i < CAND_NUM; i++) begin
      w_net_pt[i]  = r_slot_pt[i];
      w_net_idx[i] = IDX_WIDTH'(i);
    end
    for (int k = 2; k <= CAND_NUM; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < CAND_NUM; i++) begin
          w_l = i ^ j;
          if (w_l > i) begin
            w_i_higher = (w_net_pt[i] > w_net_pt[w_l]) ||
                         ((w_net_pt[i] == w_net_pt[w_l]) && (w_net_idx[i] < w_net_idx[w_l]));
            if (((i & k) == 0) ? !w_i_higher : w_i_higher) begin
              w_tmp_pt          = w_net_pt[i];
              w_tmp_idx         = w_net_idx[i];
              w_net_pt[i]       = w_net_pt[w_l];
              w_net_idx[i]      = w_net_idx[w_l];
              w_net_pt[w_l]     = w_tmp_pt;
              w_net_idx[w_l]    = w_tmp_idx;
            end
          end
        end
      end
    end
  end

  // Rank capture: latch the top OUT_NUM network outputs at the end of SORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < OUT_NUM; r++) begin
        r_rank_pt[r]  <= '0;
        r_rank_idx[r] <= '0;
      end
    end else if (w_sort_done) begin
      for (int r = 0; r < OUT_NUM; r++) begin
        r_rank_pt[r]  <= w_net_pt[r];
        r_rank_idx[r] <= w_net_idx[r];
      end
    end
  end

  // Output mux: current rank in DRAIN, zeros otherwise.
  always_comb begin
    out_pt  = '0;
    out_idx = '0;
    if (r_state == S_DRAIN) begin
      for (int r = 0; r < OUT_NUM; r++) begin
        if (r_rd_ptr == RD_WIDTH'(r)) begin
          out_pt  = r_rank_pt[r];
          out_idx = r_rank_idx[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sorter_stream.sv
// Scoreboard bench for bitonic_sorter_stream with directed frames.
module tb_bitonic_sorter_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_pt = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_pt;
  logic [3:0] out_idx;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] pt;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t sb_q[$];

  bitonic_sorter_stream #(
    .CAND_NUM(16), .PT_WIDTH(4), .OUT_NUM(4), .SORT_LAT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int pt, input int idx, input bit last);
    exp_t e;
    e.pt = 4'(pt);
    e.idx = 4'(idx);
    e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("timeout_in_ready", 0, 1);
  endtask

  task automatic send_word(input int pt, input bit last);
    in_valid = 1'b1;
    in_pt = 4'(pt);
    in_last = last;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0 || !in_ready) check("timeout_drain", 0, 1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  // Monitor: compare each handshaken output with the scoreboard head, and
  // verify outputs stay stable while out_ready is low.
  logic       hold_flag = 1'b0;
  logic [3:0] hold_pt;
  logic [3:0] hold_idx;
  logic       hold_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_flag = 1'b0;
    end else if (out_valid) begin
      if (hold_flag) begin
        check("hold_pt", int'(out_pt), int'(hold_pt));
        check("hold_idx", int'(out_idx), int'(hold_idx));
        check("hold_last", int'(out_last), int'(hold_last));
        hold_flag = 1'b0;
      end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_pt", int'(out_pt), int'(e.pt));
          check("out_idx", int'(out_idx), int'(e.idx));
          check("out_last", int'(out_last), int'(e.last));
        end
      end else begin
        hold_flag = 1'b1;
        hold_pt = out_pt;
        hold_idx = out_idx;
        hold_last = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pa [16];
    int pc [4];

    // Reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_pt", int'(out_pt), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full frame pt[i]=i
    push_exp(15, 15, 0); push_exp(14, 14, 0); push_exp(13, 13, 0); push_exp(12, 12, 1);
    for (int i = 0; i < 16; i++) send_word(i, 1'b0);
    check("sort_busy", int'(busy), 1);
    check("sort_in_ready", int'(in_ready), 0);
    wait_out_valid(lat);
    check("latency", lat, 5);
    wait_idle();

    // 2: all pt=7, tie order by index
    push_exp(7, 0, 0); push_exp(7, 1, 0); push_exp(7, 2, 0); push_exp(7, 3, 1);
    for (int i = 0; i < 16; i++) send_word(7, 1'b0);
    wait_idle();

    // 3: short frame 2,9,5 with padding
    push_exp(9, 1, 0); push_exp(5, 2, 0); push_exp(2, 0, 0); push_exp(0, 3, 1);
    send_word(2, 1'b0); send_word(9, 1'b0); send_word(5, 1'b1);
    wait_idle();

    // 4: out_ready toggles 1,0,0,1 during DRAIN
    pa = '{5, 11, 3, 11, 0, 9, 14, 2, 14, 6, 1, 7, 8, 4, 10, 12};
    push_exp(14, 6, 0); push_exp(14, 8, 0); push_exp(12, 15, 0); push_exp(11, 1, 1);
    for (int i = 0; i < 16; i++) send_word(pa[i], 1'b0);
    wait_out_valid(lat);
    pc = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      out_ready = pc[i][0];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // 5: in_valid held high through SORT/DRAIN; next frame starts at idx 0
    push_exp(15, 3, 0); push_exp(14, 6, 0); push_exp(13, 9, 0); push_exp(12, 12, 1);
    push_exp(15, 0, 0); push_exp(0, 1, 0); push_exp(0, 2, 0); push_exp(0, 3, 1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_pt = 4'((i * 5) % 16);
      in_last = 1'b0;
      wait_ready();
      @(posedge clk); #1;
    end
    in_pt = 4'd15;
    in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_idle();

    // 6: reset pulse while rank 1 is presented
    push_exp(15, 15, 0);
    for (int i = 0; i < 16; i++) send_word(i, 1'b0);
    wait_out_valid(lat);
    @(posedge clk); #1;
    check("rank1_pt_before_rst", int'(out_pt), 14);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(3, 0, 0); push_exp(0, 1, 0); push_exp(0, 2, 0); push_exp(0, 3, 1);
    send_word(3, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
